// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the transmit path of a single UART transceiver among NUM_REQ
// requesters. Requesters offer words on valid/ready ports. A round-robin
// choice picks one word, which is presented on the transceiver's parallel
// input together with a one-cycle write strobe. The transceiver's busy flag is
// then followed through its rise and fall, so that only one word is ever in
// flight. If busy never rises within BUSY_RISE_TIMEOUT cycles, the word is
// dropped and timeout_error pulses.
//
// Parameters
//   NUM_REQ            number of requesters (>= 1)
//   TX_WORD_LENGTH     UART data bits per word (6, 7 or 8)
//   TX_NO_OF_WORDS     words per transmit buffer
//   BUSY_RISE_TIMEOUT  cycles allowed for tx_busy_in to rise after a strobe
//
// Ports (W = TX_WORD_LENGTH*TX_NO_OF_WORDS, G = max(1, clog2(NUM_REQ)))
//   clk                    in   1          block clock (same as transceiver)
//   reset                  in   1          asynchronous, active-low reset
//   req_valid              in   NUM_REQ    bit i: requester i offers a word
//   req_data               in   NUM_REQ*W  requester i word at [i*W +: W]
//   req_ready              out  NUM_REQ    one-cycle accept pulse, one-hot
//   tx_parallel_data_out   out  W          word to the transceiver
//   tx_data_wr_enable_out  out  1          one-cycle write strobe
//   tx_busy_in             in   1          transceiver busy flag
//   arb_busy               out  1          high whenever not idle
//   arb_grant_id           out  G          current / most recent grant index
//   timeout_error          out  1          one-cycle pulse, busy failed to rise
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int TX_WORD_LENGTH    = 8,
  parameter int TX_NO_OF_WORDS    = 1,
  parameter int BUSY_RISE_TIMEOUT = 4,
  localparam int W = TX_WORD_LENGTH * TX_NO_OF_WORDS,
  localparam int G = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [W-1:0]         tx_parallel_data_out,
  output logic                 tx_data_wr_enable_out,
  input  logic                 tx_busy_in,
  output logic                 arb_busy,
  output logic [G-1:0]         arb_grant_id,
  output logic                 timeout_error
);

  localparam int CNT_W = $clog2(BUSY_RISE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_t;

  state_t           state;
  logic [G-1:0]     last_grant;
  logic [CNT_W-1:0] rise_cnt;

  logic             pick_found;
  logic [G-1:0]     pick_idx;
  logic [W-1:0]     pick_word;
  logic [NUM_REQ-1:0] pick_onehot;

  // Round-robin search: first valid requester starting just after the last
  // grant, wrapping modulo NUM_REQ. last_grant + k never exceeds
  // 2*NUM_REQ-1, so a single conditional subtraction performs the wrap.
  always_comb begin
    int cand;
    logic [G-1:0] cand_g;
    cand       = 0;
    cand_g     = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_g = G'(cand);
      if (!pick_found && req_valid[cand_g]) begin
        pick_found = 1'b1;
        pick_idx   = cand_g;
      end
    end
  end

  // Word and accept vector of the chosen requester.
  always_comb begin
    pick_word   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == G'(i)) begin
        pick_word      = req_data[i*W +: W];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Control FSM. Every output is a register; strobes default low each cycle
  // so they can only ever be one cycle wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      last_grant            <= G'(NUM_REQ - 1);
      rise_cnt              <= '0;
      req_ready             <= '0;
      tx_parallel_data_out  <= '0;
      tx_data_wr_enable_out <= 1'b0;
      arb_busy              <= 1'b0;
      arb_grant_id          <= '0;
      timeout_error         <= 1'b0;
    end else begin
      req_ready             <= '0;
      tx_data_wr_enable_out <= 1'b0;
      timeout_error         <= 1'b0;

      case (state)
        IDLE: begin
          // A busy transceiver blocks any grant, even with requests pending.
          if (!tx_busy_in && pick_found) begin
            state                 <= WRITE;
            tx_parallel_data_out  <= pick_word;
            arb_grant_id          <= pick_idx;
            last_grant            <= pick_idx;
            req_ready             <= pick_onehot;
            tx_data_wr_enable_out <= 1'b1;
            arb_busy              <= 1'b1;
          end
        end

        WRITE: begin
          rise_cnt <= '0;
          state    <= WAIT_RISE;
        end

        WAIT_RISE: begin
          // Busy rising takes precedence over the timeout on the last cycle.
          if (tx_busy_in) begin
            state <= WAIT_FALL;
          end else if (rise_cnt == CNT_W'(BUSY_RISE_TIMEOUT - 1)) begin
            // The word is considered consumed; it is not offered again.
            timeout_error <= 1'b1;
            arb_busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            rise_cnt <= rise_cnt + CNT_W'(1);
          end
        end

        WAIT_FALL: begin
          if (!tx_busy_in) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
